// File: rtl/dma_bus_arbiter_if.sv
// Signal bundle between the sm83 bus port, the system memory fabric and the OAM write port.
// The arbiter uses the master modport; the core/fabric/OAM side uses the slave modport.
interface dma_bus_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write;
  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_write, mem_rdata,
    output cpu_rdata, mem_addr, mem_wdata, mem_write,
    output oam_addr, oam_wdata, oam_write, dma_active
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_write, mem_rdata,
    input  cpu_rdata, mem_addr, mem_wdata, mem_write,
    input  oam_addr, oam_wdata, oam_write, dma_active
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// CPU/fabric arbiter owning the OAM DMA register at 0xFF46 and the 160-byte OAM copy engine.
// Define DMA_BUS_CONFLICT_EN to return the in-flight DMA byte on blocked CPU reads during a transfer.
module dma_bus_arbiter #(
  parameter int DMA_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  dma_bus_arbiter_if.master bus
);
  localparam int            CW      = $clog2(DMA_LEN);
  localparam logic [CW-1:0] LAST    = CW'(DMA_LEN - 1);
  localparam logic [15:0]   DMA_REG = 16'hFF46;

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t        state, state_d;
  logic [7:0]    src_reg, src_d;
  logic [1:0]    delay, delay_d;
  logic [CW-1:0] count, count_d;
  logic          pipe_valid, pipe_valid_d;
  logic [7:0]    pipe_data, pipe_data_d;
  logic [7:0]    pipe_idx, pipe_idx_d;

  logic reg_hit, reg_write, hram, dma_owns;

  assign reg_hit   = (bus.cpu_addr == DMA_REG);
  assign reg_write = reg_hit && bus.cpu_write;
  assign hram      = (bus.cpu_addr >= 16'hFF80) && (bus.cpu_addr <= 16'hFFFE);
  // An HRAM access during XFER borrows the fabric for that clock; the DMA read retries next clock.
  assign dma_owns  = (state == XFER) && !hram;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state;
    src_d        = src_reg;
    delay_d      = delay;
    count_d      = count;
    pipe_valid_d = 1'b0;
    pipe_data_d  = pipe_data;
    pipe_idx_d   = pipe_idx;

    case (state)
      IDLE: ;
      START: begin
        if (delay == 2'd0) begin
          state_d = XFER;
          count_d = '0;
        end else begin
          delay_d = delay - 2'd1;
        end
      end
      XFER: begin
        if (dma_owns) begin
          pipe_valid_d = 1'b1;
          pipe_data_d  = bus.mem_rdata;
          pipe_idx_d   = 8'(count);
          if (count == LAST) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A register write (re)starts the transfer from any state; a byte already read still lands.
    if (reg_write) begin
      src_d   = bus.cpu_wdata;
      delay_d = 2'(START_DELAY - 1);
      count_d = '0;
      state_d = START;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      src_reg    <= 8'h00;
      delay      <= 2'd0;
      count      <= '0;
      pipe_valid <= 1'b0;
      pipe_data  <= 8'h00;
      pipe_idx   <= 8'h00;
    end else begin
      state      <= state_d;
      src_reg    <= src_d;
      delay      <= delay_d;
      count      <= count_d;
      pipe_valid <= pipe_valid_d;
      pipe_data  <= pipe_data_d;
      pipe_idx   <= pipe_idx_d;
    end
  end

  always_comb begin
    bus.mem_addr   = dma_owns ? {src_reg, 8'(count)} : bus.cpu_addr;
    bus.mem_wdata  = bus.cpu_wdata;
    bus.mem_write  = bus.cpu_write && !reg_hit && ((state == IDLE) || hram);
    bus.oam_write  = pipe_valid;
    bus.oam_addr   = pipe_idx;
    bus.oam_wdata  = pipe_data;
    bus.dma_active = (state != IDLE) || pipe_valid || reg_write;

    if (reg_hit)
      bus.cpu_rdata = src_reg;
    else if ((state == IDLE) || hram)
      bus.cpu_rdata = bus.mem_rdata;
`ifdef DMA_BUS_CONFLICT_EN
    else if (state == XFER)
      bus.cpu_rdata = bus.mem_rdata;
`endif
    else
      bus.cpu_rdata = 8'hFF;
  end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed transfers over random memory, checked
// against an expected-OAM-write list derived from the transfer rules and latency formula.
module tb_dma_bus_arbiter;
  localparam int DMA_LEN = 160;
  localparam int SD      = 1;
  localparam int SD_LONG = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_bus_arbiter_if bus ();
  dma_bus_arbiter_if bus4 ();

  dma_bus_arbiter #(.DMA_LEN(DMA_LEN), .START_DELAY(SD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  dma_bus_arbiter #(.DMA_LEN(DMA_LEN), .START_DELAY(SD_LONG)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  // Read-only fabric model: combinational read of a 64 KiB array.
  logic [7:0] mem [0:65535];
  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus4.mem_rdata = mem[bus4.mem_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int unsigned cyc;
    logic [7:0]  idx;
    logic [7:0]  data;
  } oam_ev_t;

  oam_ev_t     oam_log[$];
  int unsigned act_log[$];
  int unsigned oam4_log[$];

  // Mid-cycle monitor: OAM writes and active cycles, tagged with the cycle number.
  always @(negedge clk) begin
    if (bus.oam_write === 1'b1)
      oam_log.push_back(oam_ev_t'{cyc: cyc, idx: bus.oam_addr, data: bus.oam_wdata});
    if (bus.dma_active === 1'b1) act_log.push_back(cyc);
    if (bus4.oam_write === 1'b1) oam4_log.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_write = w;
  endtask

  task automatic drive4(input logic [15:0] a, input logic [7:0] d, input logic w);
    bus4.cpu_addr  = a;
    bus4.cpu_wdata = d;
    bus4.cpu_write = w;
  endtask

  // Reference model: a transfer from page src writes byte i of that page to OAM index i, in order.
  logic [15:0] exp_q[$];

  function automatic void expect_bytes(input logic [7:0] src, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i), mem[{src, 8'(i)}]});
  endfunction

  task automatic check_log(input string tag, input int base);
    check({tag, " count"}, 32'(oam_log.size() - base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && base + k < oam_log.size(); k++)
      check(tag, 32'({oam_log[base + k].idx, oam_log[base + k].data}), 32'(exp_q[k]));
    exp_q.delete();
  endtask

  function automatic int unsigned log_cyc(input int k);
    return (k < oam_log.size()) ? oam_log[k].cyc : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.dma_active !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.dma_active), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  src;
    logic [15:0] a;
    int          t, t2, base, act_base, n;

    for (int i = 0; i < 65536; i++) mem[16'(i)] = 8'($urandom);
    for (int i = 0; i < DMA_LEN; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;

    rst = 1'b0;
    drive(16'h1234, 8'h00, 1'b0);
    drive4(16'h0000, 8'h00, 1'b0);
    repeat (3) tick();
    check("reset oam_write", 32'(bus.oam_write), 32'd0);
    check("reset dma_active", 32'(bus.dma_active), 32'd0);
    check("reset mem_write", 32'(bus.mem_write), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'h1234);
    rst = 1'b1;
    tick();

    // Idle passthrough and register reset value
    drive(16'hC005, 8'h00, 1'b0); #1;
    check("idle mem_addr", 32'(bus.mem_addr), 32'hC005);
    check("idle rdata", 32'(bus.cpu_rdata), 32'(mem[16'hC005]));
    tick(); drive(16'hD123, 8'h77, 1'b1); #1;
    check("idle mem_write", 32'(bus.mem_write), 32'd1);
    check("idle wr addr", 32'(bus.mem_addr), 32'hD123);
    check("idle wr data", 32'(bus.mem_wdata), 32'h77);
    tick(); drive(16'hFF46, 8'h00, 1'b0); #1;
    check("ff46 reset read", 32'(bus.cpu_rdata), 32'h00);

    // Full transfer from 0xC000 with exact timing
    tick();
    base = oam_log.size(); act_base = act_log.size(); t = cyc;
    drive(16'hFF46, 8'hC0, 1'b1); #1;
    check("ff46 write not forwarded", 32'(bus.mem_write), 32'd0);
    check("active on write clock", 32'(bus.dma_active), 32'd1);
    tick(); drive(16'h0000, 8'h00, 1'b0);
    wait_done("xfer1 done");
    expect_bytes(8'hC0, DMA_LEN);
    check_log("xfer1", base);
    check("xfer1 first write cyc", log_cyc(base), 32'(t + SD + 2));
    check("xfer1 last write cyc", log_cyc(base + DMA_LEN - 1), 32'(t + SD + DMA_LEN + 1));
    check("active cycles", 32'(act_log.size() - act_base), 32'(SD + DMA_LEN + 2));
    if (act_log.size() > act_base) begin
      check("active first", act_log[act_base], 32'(t));
      check("active last", act_log[act_log.size() - 1], 32'(t + SD + DMA_LEN + 1));
    end

    // Register readback after writing 0x80 (also runs a transfer from random data)
    tick();
    base = oam_log.size();
    drive(16'hFF46, 8'h80, 1'b1); #1;
    check("ff46 80 not forwarded", 32'(bus.mem_write), 32'd0);
    tick(); drive(16'hFF46, 8'h00, 1'b0); #1;
    check("ff46 readback", 32'(bus.cpu_rdata), 32'h80);
    tick(); drive(16'h0000, 8'h00, 1'b0);
    wait_done("xfer80 done");
    expect_bytes(8'h80, DMA_LEN);
    check_log("xfer80", base);

    // CPU gating during XFER from a random page
    src = 8'($urandom_range(255, 0));
    tick();
    base = oam_log.size(); t = cyc;
    drive(16'hFF46, src, 1'b1);
    tick(); drive(16'h0000, 8'h00, 1'b0);
    while (cyc < t + 10) tick();
    drive(16'hC123, 8'h00, 1'b0); #1;
`ifdef DMA_BUS_CONFLICT_EN
    check("blocked read", 32'(bus.cpu_rdata), 32'(mem[{src, 8'(10 - 1 - SD)}]));
`else
    check("blocked read", 32'(bus.cpu_rdata), 32'hFF);
`endif
    tick(); drive(16'hFF90, 8'h33, 1'b1); #1;
    check("hram write strobe", 32'(bus.mem_write), 32'd1);
    check("hram write addr", 32'(bus.mem_addr), 32'hFF90);
    check("hram write data", 32'(bus.mem_wdata), 32'h33);
    tick(); drive(16'hD000, 8'h11, 1'b1); #1;
    check("blocked write", 32'(bus.mem_write), 32'd0);
    tick(); drive(16'h0000, 8'h00, 1'b0);
    wait_done("gated done");
    expect_bytes(src, DMA_LEN);
    check_log("gated xfer", base);

    // Restart at byte 50 with page 0xD0
    tick();
    base = oam_log.size(); t = cyc;
    drive(16'hFF46, 8'hC0, 1'b1);
    tick(); drive(16'h0000, 8'h00, 1'b0);
    while (cyc < t + 1 + SD + 50) tick();
    t2 = cyc;
    drive(16'hFF46, 8'hD0, 1'b1);
    tick(); drive(16'h0000, 8'h00, 1'b0);
    wait_done("restart done");
    expect_bytes(8'hC0, 51);
    expect_bytes(8'hD0, DMA_LEN);
    check_log("restart", base);
    check("restart byte50 cyc", log_cyc(base + 50), 32'(t2 + 1));
    check("restart first new cyc", log_cyc(base + 51), 32'(t2 + SD + 2));

    // Reset at byte 20 aborts at once
    tick();
    base = oam_log.size(); t = cyc;
    drive(16'hFF46, 8'hC0, 1'b1);
    tick(); drive(16'h0000, 8'h00, 1'b0);
    while (cyc < t + 1 + SD + 20) tick();
    rst = 1'b0; #1;
    check("abort oam_write", 32'(bus.oam_write), 32'd0);
    check("abort dma_active", 32'(bus.dma_active), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    drive(16'hC010, 8'h00, 1'b0); #1;
    check("post-reset mem_addr", 32'(bus.mem_addr), 32'hC010);
    check("post-reset rdata", 32'(bus.cpu_rdata), 32'(mem[16'hC010]));
    tick(); drive(16'hFF46, 8'h00, 1'b0); #1;
    check("post-reset ff46", 32'(bus.cpu_rdata), 32'h00);
    repeat (5) tick();
    check("post-reset idle", 32'(bus.dma_active), 32'd0);
    expect_bytes(8'hC0, 19);
    check_log("abort", base);

    // START_DELAY=4 instance: CPU keeps the fabric address until the first DMA read
    drive(16'h0000, 8'h00, 1'b0);
    tick(); t = cyc;
    drive4(16'hFF46, 8'hC0, 1'b1);
    for (int k = 1; k <= SD_LONG; k++) begin
      tick();
      a = 16'($urandom_range(16'hFEFF, 0));
      drive4(a, 8'h00, 1'b0); #1;
      check("sd4 passthrough", 32'(bus4.mem_addr), 32'(a));
    end
    tick(); drive4(16'h0000, 8'h00, 1'b0);
    n = 0;
    while (bus4.dma_active !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    check("sd4 done", 32'(bus4.dma_active), 32'd0);
    check("sd4 write count", 32'(oam4_log.size()), 32'(DMA_LEN));
    if (oam4_log.size() > 0)
      check("sd4 first write cyc", oam4_log[0], 32'(t + SD_LONG + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
